// File: rtl/cell_link_merge_arbiter_if.sv
// Stream bundle for the cell-link merge: two packet sources in, one merged stream out.
// The master side is the packet source / consumer pair, the slave side is the merger.
interface cell_link_merge_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s0TVALID;
    logic                  s0TLAST;
    logic [DATA_WIDTH-1:0] s0TDATA;
    logic                  s1TVALID;
    logic                  s1TLAST;
    logic [DATA_WIDTH-1:0] s1TDATA;
    logic                  mTVALID;
    logic                  mTLAST;
    logic [DATA_WIDTH-1:0] mTDATA;
    logic                  s0Overflow;
    logic                  s1Overflow;
    logic                  busy;

    modport master (
        output s0TVALID, s0TLAST, s0TDATA,
        output s1TVALID, s1TLAST, s1TDATA,
        input  mTVALID, mTLAST, mTDATA,
        input  s0Overflow, s1Overflow, busy
    );

    modport slave (
        input  s0TVALID, s0TLAST, s0TDATA,
        input  s1TVALID, s1TLAST, s1TDATA,
        output mTVALID, mTLAST, mTDATA,
        output s0Overflow, s1Overflow, busy
    );
endinterface

// File: rtl/cell_link_merge_arbiter.sv
// Packet-granular round-robin merge of the cell-link RX stream and the local stream.
// Each input owns a packet-mode FIFO; only fully committed packets are ever read out.
module cell_link_merge_arbiter #(
    parameter int FIFO_AW    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      auroraUserClk,
    input  logic                      muxResetN,
    cell_link_merge_arbiter_if.slave  link
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    logic [1:0]                  in_valid;
    logic [1:0]                  in_last;
    logic [1:0][DATA_WIDTH-1:0]  in_data;

    logic [FIFO_AW:0]  wr_ptr     [2];
    logic [FIFO_AW:0]  commit_ptr [2];
    logic [FIFO_AW:0]  rd_ptr     [2];
    logic [FIFO_AW:0]  pkt_count  [2];
    logic [DATA_WIDTH:0] mem      [2][DEPTH];
    logic [DATA_WIDTH:0] head     [2];

    logic [1:0] discard;
    logic [1:0] overflow;
    logic [1:0] full;
    logic [1:0] write_now;
    logic [1:0] drop_now;
    logic [1:0] commit_now;
    logic [1:0] pop;

    state_t                state;
    logic                  last_grant;
    logic                  stage_valid;
    logic                  stage_last;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy_q;

    assign in_valid = {link.s1TVALID, link.s0TVALID};
    assign in_last  = {link.s1TLAST,  link.s0TLAST};
    assign in_data  = {link.s1TDATA,  link.s0TDATA};

    // Uncommitted words count as occupied, so a packet that cannot fit is dropped whole.
    always_comb begin
        full       = '0;
        write_now  = '0;
        drop_now   = '0;
        commit_now = '0;
        head[0]    = '0;
        head[1]    = '0;
        for (int p = 0; p < 2; p++) begin
            full[p]       = (wr_ptr[p] - rd_ptr[p]) == FULL_LEVEL;
            write_now[p]  = in_valid[p] && !discard[p] && !full[p];
            drop_now[p]   = in_valid[p] && !discard[p] && full[p];
            commit_now[p] = write_now[p] && in_last[p];
            head[p]       = mem[p][rd_ptr[p][FIFO_AW-1:0]];
        end
    end

    assign pop[0] = (state == SEND0) && head[0][DATA_WIDTH];
    assign pop[1] = (state == SEND1) && head[1][DATA_WIDTH];

    always_ff @(posedge auroraUserClk) begin
        if (!muxResetN) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p]     <= '0;
                commit_ptr[p] <= '0;
                pkt_count[p]  <= '0;
            end
            discard  <= '0;
            overflow <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                overflow[p] <= drop_now[p];
                if (write_now[p]) begin
                    mem[p][wr_ptr[p][FIFO_AW-1:0]] <= {in_last[p], in_data[p]};
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                if (commit_now[p]) begin
                    commit_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                // A drop on the TLAST word itself ends the packet, so no discard phase follows.
                if (drop_now[p]) begin
                    wr_ptr[p]  <= commit_ptr[p];
                    discard[p] <= !in_last[p];
                end else if (in_valid[p] && discard[p] && in_last[p]) begin
                    discard[p] <= 1'b0;
                end
                if (commit_now[p] && !pop[p]) begin
                    pkt_count[p] <= pkt_count[p] + 1'b1;
                end else if (pop[p] && !commit_now[p]) begin
                    pkt_count[p] <= pkt_count[p] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (!muxResetN) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            rd_ptr[0]   <= '0;
            rd_ptr[1]   <= '0;
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            stage_data  <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            busy_q      <= 1'b0;
        end else begin
            stage_valid <= 1'b0;
            stage_last  <= 1'b0;
            out_valid   <= stage_valid;
            out_last    <= stage_last;
            out_data    <= stage_data;
            case (state)
                IDLE: begin
                    if (pkt_count[0] != '0 && (pkt_count[1] == '0 || last_grant)) begin
                        state      <= SEND0;
                        last_grant <= 1'b0;
                        busy_q     <= 1'b1;
                    end else if (pkt_count[1] != '0) begin
                        state      <= SEND1;
                        last_grant <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                SEND0: begin
                    stage_valid <= 1'b1;
                    stage_last  <= head[0][DATA_WIDTH];
                    stage_data  <= head[0][DATA_WIDTH-1:0];
                    rd_ptr[0]   <= rd_ptr[0] + 1'b1;
                    if (head[0][DATA_WIDTH]) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                SEND1: begin
                    stage_valid <= 1'b1;
                    stage_last  <= head[1][DATA_WIDTH];
                    stage_data  <= head[1][DATA_WIDTH-1:0];
                    rd_ptr[1]   <= rd_ptr[1] + 1'b1;
                    if (head[1][DATA_WIDTH]) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign link.mTVALID    = out_valid;
    assign link.mTLAST     = out_last;
    assign link.mTDATA     = out_data;
    assign link.s0Overflow = overflow[0];
    assign link.s1Overflow = overflow[1];
    assign link.busy       = busy_q;
endmodule

// File: tb/tb_cell_link_merge_arbiter.sv
// Bench for the cell-link merge: a default-depth instance and a 16-deep instance,
// checked against a packet-level scheduling model of the round-robin merge.
module tb_cell_link_merge_arbiter;
    localparam int INF = 32'h7fffffff;

    typedef struct { logic last; logic [31:0] data; } word_t;
    typedef struct { int commit_edge; int len; } pkt_t;
    typedef struct { int edge_i; logic last; logic [31:0] data; } obs_t;

    logic aurora_user_clk;
    logic mux_reset_n;

    cell_link_merge_arbiter_if #(.DATA_WIDTH(32)) if8 ();
    cell_link_merge_arbiter_if #(.DATA_WIDTH(32)) if4 ();

    cell_link_merge_arbiter #(.FIFO_AW(8), .DATA_WIDTH(32)) dut8 (
        .auroraUserClk (aurora_user_clk),
        .muxResetN     (mux_reset_n),
        .link          (if8)
    );

    cell_link_merge_arbiter #(.FIFO_AW(4), .DATA_WIDTH(32)) dut4 (
        .auroraUserClk (aurora_user_clk),
        .muxResetN     (mux_reset_n),
        .link          (if4)
    );

    int n_asserts;
    int n_fail;
    int edge_n;
    int busy_cycles;
    int depth_of [2];
    int lg [2];
    int free_edge [2];
    int cur_len [4];
    bit dropping [4];
    int exp_ovf [4];
    int exp_ovf_edge [4];
    int got_ovf [4];
    int got_ovf_edge [4];
    word_t cur_q [4][$];
    word_t pw [4][$];
    pkt_t  pq [4][$];
    obs_t  obs_q [2][$];
    obs_t  exp_q [$];

    initial aurora_user_clk = 1'b0;
    always #5 aurora_user_clk = ~aurora_user_clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_asserts++;
        assert (got === want) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock: sample both merged streams, overflow pulses and busy just after the edge.
    task automatic tick();
        obs_t o;
        @(posedge aurora_user_clk);
        #1;
        edge_n++;
        if (if8.mTVALID === 1'b1) begin
            o.edge_i = edge_n; o.last = if8.mTLAST; o.data = if8.mTDATA;
            obs_q[0].push_back(o);
        end
        if (if4.mTVALID === 1'b1) begin
            o.edge_i = edge_n; o.last = if4.mTLAST; o.data = if4.mTDATA;
            obs_q[1].push_back(o);
        end
        if (if8.s0Overflow === 1'b1) begin got_ovf[0]++; got_ovf_edge[0] = edge_n; end
        if (if8.s1Overflow === 1'b1) begin got_ovf[1]++; got_ovf_edge[1] = edge_n; end
        if (if4.s0Overflow === 1'b1) begin got_ovf[2]++; got_ovf_edge[2] = edge_n; end
        if (if4.s1Overflow === 1'b1) begin got_ovf[3]++; got_ovf_edge[3] = edge_n; end
        if (if8.busy === 1'b1) busy_cycles++;
    endtask

    task automatic clear_inputs();
        if8.s0TVALID = 0; if8.s0TLAST = 0; if8.s0TDATA = '0;
        if8.s1TVALID = 0; if8.s1TLAST = 0; if8.s1TDATA = '0;
        if4.s0TVALID = 0; if4.s0TLAST = 0; if4.s0TDATA = '0;
        if4.s1TVALID = 0; if4.s1TLAST = 0; if4.s1TDATA = '0;
    endtask

    task automatic record_word(input int d, input int p, input bit last, input logic [31:0] data);
        int k;
        word_t w;
        pkt_t pk;
        k = d * 2 + p;
        if (!dropping[k]) begin
            cur_len[k]++;
            if (cur_len[k] > depth_of[d]) begin
                dropping[k] = 1;
                cur_q[k].delete();
                exp_ovf[k]++;
                exp_ovf_edge[k] = edge_n;
            end else begin
                w.last = last; w.data = data;
                cur_q[k].push_back(w);
            end
        end
        if (last) begin
            if (!dropping[k]) begin
                while (cur_q[k].size() > 0) pw[k].push_back(cur_q[k].pop_front());
                pk.commit_edge = edge_n;
                pk.len = cur_len[k];
                pq[k].push_back(pk);
            end
            cur_q[k].delete();
            cur_len[k] = 0;
            dropping[k] = 0;
        end
    endtask

    task automatic apply_stimulus(input int d, input bit v0, input bit l0, input logic [31:0] x0,
                                  input bit v1, input bit l1, input logic [31:0] x1);
        clear_inputs();
        if (d == 0) begin
            if8.s0TVALID = v0; if8.s0TLAST = l0; if8.s0TDATA = x0;
            if8.s1TVALID = v1; if8.s1TLAST = l1; if8.s1TDATA = x1;
        end else begin
            if4.s0TVALID = v0; if4.s0TLAST = l0; if4.s0TDATA = x0;
            if4.s1TVALID = v1; if4.s1TLAST = l1; if4.s1TDATA = x1;
        end
        tick();
        if (v0) record_word(d, 0, l0, x0);
        if (v1) record_word(d, 1, l1, x1);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    task automatic send_packet(input int d, input int p, input int len, input logic [31:0] base);
        for (int i = 0; i < len; i++) begin
            if (p == 0) apply_stimulus(d, 1, i == len - 1, base + i, 0, 0, '0);
            else        apply_stimulus(d, 0, 0, '0, 1, i == len - 1, base + i);
        end
    endtask

    task automatic model_reset(input int r);
        for (int d = 0; d < 2; d++) begin
            lg[d] = 1;
            free_edge[d] = r + 1;
        end
        for (int k = 0; k < 4; k++) begin
            cur_q[k].delete(); pw[k].delete(); pq[k].delete();
            cur_len[k] = 0; dropping[k] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        mux_reset_n = 0;
        tick();
        mux_reset_n = 1;
        model_reset(edge_n);
    endtask

    // Packet-level schedule: a packet granted at decision edge t emits its words at
    // t+2 .. t+len+1 and the arbiter decides again at t+len+1.
    task automatic build_expected(input int d, input int cut);
        int t, e0, e1, g, k0, k1;
        pkt_t pk;
        word_t w;
        obs_t o;
        exp_q.delete();
        k0 = d * 2;
        k1 = d * 2 + 1;
        while (pq[k0].size() > 0 || pq[k1].size() > 0) begin
            e0 = (pq[k0].size() > 0) ? pq[k0][0].commit_edge + 1 : INF;
            e1 = (pq[k1].size() > 0) ? pq[k1][0].commit_edge + 1 : INF;
            t = free_edge[d];
            if (t < e0 && t < e1) t = (e0 < e1) ? e0 : e1;
            if (e0 <= t && (e1 > t || lg[d] == 1)) g = 0;
            else g = 1;
            lg[d] = g;
            pk = pq[d * 2 + g].pop_front();
            for (int i = 0; i < pk.len; i++) begin
                w = pw[d * 2 + g].pop_front();
                o.edge_i = t + 2 + i; o.last = w.last; o.data = w.data;
                if (o.edge_i < cut) exp_q.push_back(o);
            end
            free_edge[d] = t + pk.len + 1;
        end
    endtask

    task automatic compare_phase(input int d, input string tag);
        int n;
        int k;
        check_output({tag, " word count"}, obs_q[d].size(), exp_q.size());
        n = (obs_q[d].size() < exp_q.size()) ? obs_q[d].size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s word %0d data", tag, i), obs_q[d][i].data, exp_q[i].data);
            check_output($sformatf("%s word %0d last", tag, i), obs_q[d][i].last, exp_q[i].last);
            check_output($sformatf("%s word %0d edge", tag, i), obs_q[d][i].edge_i, exp_q[i].edge_i);
        end
        for (int p = 0; p < 2; p++) begin
            k = d * 2 + p;
            check_output($sformatf("%s s%0d overflow pulses", tag, p), got_ovf[k], exp_ovf[k]);
            if (exp_ovf[k] > 0)
                check_output($sformatf("%s s%0d overflow edge", tag, p), got_ovf_edge[k], exp_ovf_edge[k]);
            got_ovf[k] = 0; exp_ovf[k] = 0;
        end
        obs_q[d].delete();
    endtask

    initial begin
        int last_edge;
        int cut;
        int rem [2];
        bit v [2];
        bit l [2];
        logic [31:0] x [2];

        n_asserts = 0; n_fail = 0; edge_n = 0; busy_cycles = 0;
        depth_of[0] = 256; depth_of[1] = 16;
        for (int k = 0; k < 4; k++) begin
            exp_ovf[k] = 0; got_ovf[k] = 0; exp_ovf_edge[k] = 0; got_ovf_edge[k] = 0;
        end
        mux_reset_n = 0;
        clear_inputs();
        tick();
        do_reset();

        check_output("reset mTVALID", if8.mTVALID, 0);
        check_output("reset mTLAST", if8.mTLAST, 0);
        check_output("reset mTDATA", if8.mTDATA, 0);
        check_output("reset busy", if8.busy, 0);
        check_output("reset s0Overflow", if8.s0Overflow, 0);
        check_output("reset s1Overflow", if8.s1Overflow, 0);
        check_output("reset small mTVALID", if4.mTVALID, 0);
        check_output("reset small busy", if4.busy, 0);
        obs_q[0].delete(); obs_q[1].delete();
        for (int k = 0; k < 4; k++) got_ovf[k] = 0;

        $display("[TB] single 5-word s0 packet");
        busy_cycles = 0;
        send_packet(0, 0, 5, 32'hA5BE0000);
        last_edge = edge_n;
        idle(12);
        check_output("single busy cycles", busy_cycles, 5);
        check_output("single first word edge", (obs_q[0].size() > 0) ? obs_q[0][0].edge_i : -1, last_edge + 3);
        build_expected(0, INF);
        compare_phase(0, "single");

        $display("[TB] simultaneous commits after reset");
        do_reset();
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, i == 2, 32'h00010000 + i, 1, i == 2, 32'h00020000 + i);
        idle(12);
        check_output("tie1 first data", (obs_q[0].size() > 0) ? obs_q[0][0].data : '0, 32'h00010000);
        build_expected(0, INF);
        compare_phase(0, "tie1");

        send_packet(0, 0, 1, 32'h00005555);
        idle(6);
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, i == 2, 32'h00030000 + i, 1, i == 2, 32'h00040000 + i);
        idle(12);
        check_output("tie2 s1 first", (obs_q[0].size() > 1) ? obs_q[0][1].data : '0, 32'h00040000);
        build_expected(0, INF);
        compare_phase(0, "tie2");

        $display("[TB] oversize packet on the 16-deep instance");
        send_packet(1, 1, 20, 32'h00000300);
        idle(2);
        send_packet(1, 1, 3, 32'h00000400);
        idle(12);
        build_expected(1, INF);
        compare_phase(1, "oversize");

        $display("[TB] alternating single-word packets");
        for (int i = 0; i < 200; i++) begin
            if (i % 2 == 0) apply_stimulus(0, 1, 1, $urandom, 0, 0, '0);
            else            apply_stimulus(0, 0, 0, '0, 1, 1, $urandom);
        end
        idle(480);
        build_expected(0, INF);
        compare_phase(0, "alternating");

        $display("[TB] random bursty traffic");
        rem[0] = 0; rem[1] = 0;
        for (int c = 0; c < 320; c++) begin
            for (int p = 0; p < 2; p++) begin
                v[p] = 0; l[p] = 0; x[p] = $urandom;
                if (rem[p] == 0 && c < 300 && $urandom_range(2, 0) == 0) rem[p] = $urandom_range(8, 1);
                if (rem[p] > 0 && (c >= 300 || $urandom_range(3, 0) != 0)) begin
                    v[p] = 1; l[p] = (rem[p] == 1); rem[p]--;
                end
            end
            apply_stimulus(0, v[0], l[0], x[0], v[1], l[1], x[1]);
        end
        idle(250);
        build_expected(0, INF);
        compare_phase(0, "random");

        $display("[TB] reset in the middle of an output packet");
        send_packet(0, 0, 8, 32'h00000800);
        send_packet(0, 1, 2, 32'h00000900);
        for (int w = 0; w < 30 && obs_q[0].size() < 3; w++) idle(1);
        check_output("midreset third word seen", obs_q[0].size(), 3);
        cut = edge_n + 1;
        build_expected(0, cut);
        do_reset();
        check_output("midreset mTVALID", if8.mTVALID, 0);
        check_output("midreset mTLAST", if8.mTLAST, 0);
        check_output("midreset busy", if8.busy, 0);
        idle(20);
        compare_phase(0, "midreset");

        send_packet(0, 0, 4, 32'h00000B00);
        last_edge = edge_n;
        idle(10);
        check_output("postreset first word edge", (obs_q[0].size() > 0) ? obs_q[0][0].edge_i : -1, last_edge + 3);
        build_expected(0, INF);
        compare_phase(0, "postreset");

        $display("[TB] write across wraparound while reading");
        send_packet(1, 0, 12, 32'h00000C00);
        send_packet(1, 0, 10, 32'h00000D00);
        idle(30);
        build_expected(1, INF);
        compare_phase(1, "wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
